// File: rtl/mouse_pkg.sv
// Shared types and protocol constants for the PS/2 mouse host controller.
package mouse_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    SEND_RESET,
    WAIT_RESET_SENT,
    WAIT_ACK,
    WAIT_SELFTEST,
    WAIT_ID,
    SEND_ENABLE,
    WAIT_ENABLE_SENT,
    WAIT_ENABLE_ACK,
    READ_STATUS,
    READ_DX,
    READ_DY,
    INTERRUPT
  } mouseState_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_SELFTEST = 8'hAA;
  localparam logic [7:0] RSP_ID       = 8'h00;
  localparam logic [1:0] ERR_NONE     = 2'b00;

  // States in which the receiver must be listening for a mouse byte.
  function automatic logic isReadState(input mouseState_t s);
    return (s == WAIT_ACK) || (s == WAIT_SELFTEST) || (s == WAIT_ID) ||
           (s == WAIT_ENABLE_ACK) || (s == READ_STATUS) ||
           (s == READ_DX) || (s == READ_DY);
  endfunction

endpackage

// File: rtl/mouse_master_sm_if.sv
// Signal bundle between the mouse host FSM, the PS/2 byte transceiver and
// the packet consumer.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/mouse_startup_timer.sv
// Power-up delay counter: done once count reaches CYCLES-1; saturates until cleared.
module mouse_startup_timer #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] count;

  assign done = (count == CNT_W'(CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse host: power-up wait, reset/self-test/ID handshake, enable streaming,
// then assemble 3-byte packets and pulse SEND_INTERRUPT with the packet visible.
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES = 1_000_000
) (
  input  logic              CLK,
  input  logic              RESET,
  mouse_master_sm_if.master bus
);

  mouseState_t state, nextState;
  logic [7:0]  byteToSendQ, byteToSendNxt;
  logic [7:0]  statusSh, statusShNxt;
  logic [7:0]  dxSh, dxShNxt;
  logic [7:0]  dySh, dyShNxt;
  logic [7:0]  statusQ, dxQ, dyQ;
  logic        loadPacket;
  logic        timerDone;
  logic        rxOk;

  mouse_startup_timer #(
    .CYCLES (INIT_WAIT_CYCLES)
  ) u_startup_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (state != INIT_WAIT),
    .enable (state == INIT_WAIT),
    .done   (timerDone)
  );

  assign rxOk = (bus.BYTE_ERROR_CODE == ERR_NONE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= INIT_WAIT;
      byteToSendQ <= '0;
      statusSh    <= '0;
      dxSh        <= '0;
      dySh        <= '0;
      statusQ     <= '0;
      dxQ         <= '0;
      dyQ         <= '0;
    end else begin
      state       <= nextState;
      byteToSendQ <= byteToSendNxt;
      statusSh    <= statusShNxt;
      dxSh        <= dxShNxt;
      dySh        <= dyShNxt;
      // DY is taken straight from the bus so all three change on the same edge.
      if (loadPacket) begin
        statusQ <= statusSh;
        dxQ     <= dxSh;
        dyQ     <= bus.BYTE_READ;
      end
    end
  end

  always_comb begin
    nextState     = state;
    byteToSendNxt = byteToSendQ;
    statusShNxt   = statusSh;
    dxShNxt       = dxSh;
    dyShNxt       = dySh;
    loadPacket    = 1'b0;

    unique case (state)
      INIT_WAIT: begin
        if (timerDone) begin
          nextState     = SEND_RESET;
          byteToSendNxt = CMD_RESET;
        end
      end
      SEND_RESET:      nextState = WAIT_RESET_SENT;
      WAIT_RESET_SENT: if (bus.BYTE_SENT) nextState = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.BYTE_READY) begin
          nextState = (rxOk && bus.BYTE_READ == RSP_ACK) ? WAIT_SELFTEST : INIT_WAIT;
        end
      end
      WAIT_SELFTEST: begin
        if (bus.BYTE_READY) begin
          nextState = (rxOk && bus.BYTE_READ == RSP_SELFTEST) ? WAIT_ID : INIT_WAIT;
        end
      end
      WAIT_ID: begin
        if (bus.BYTE_READY) begin
          if (rxOk && bus.BYTE_READ == RSP_ID) begin
            nextState     = SEND_ENABLE;
            byteToSendNxt = CMD_ENABLE;
          end else begin
            nextState = INIT_WAIT;
          end
        end
      end
      SEND_ENABLE:      nextState = WAIT_ENABLE_SENT;
      WAIT_ENABLE_SENT: if (bus.BYTE_SENT) nextState = WAIT_ENABLE_ACK;
      WAIT_ENABLE_ACK: begin
        if (bus.BYTE_READY) begin
          nextState = (rxOk && bus.BYTE_READ == RSP_ACK) ? READ_STATUS : INIT_WAIT;
        end
      end
      READ_STATUS: begin
        // Bytes without the always-one bit 3 cannot start a packet: drop to resync.
        if (bus.BYTE_READY) begin
          if (!rxOk) begin
            nextState = INIT_WAIT;
          end else if (bus.BYTE_READ[3]) begin
            statusShNxt = bus.BYTE_READ;
            nextState   = READ_DX;
          end
        end
      end
      READ_DX: begin
        if (bus.BYTE_READY) begin
          if (rxOk) begin
            dxShNxt   = bus.BYTE_READ;
            nextState = READ_DY;
          end else begin
            nextState = INIT_WAIT;
          end
        end
      end
      READ_DY: begin
        if (bus.BYTE_READY) begin
          if (rxOk) begin
            dyShNxt    = bus.BYTE_READ;
            loadPacket = 1'b1;
            nextState  = INTERRUPT;
          end else begin
            nextState = INIT_WAIT;
          end
        end
      end
      INTERRUPT: nextState = READ_STATUS;
      default:   nextState = INIT_WAIT;
    endcase
  end

  assign bus.SEND_BYTE      = (state == SEND_RESET) || (state == SEND_ENABLE);
  assign bus.BYTE_TO_SEND   = byteToSendQ;
  assign bus.READ_ENABLE    = isReadState(state);
  assign bus.SEND_INTERRUPT = (state == INTERRUPT);
  assign bus.MOUSE_STATUS   = statusQ;
  assign bus.MOUSE_DX       = dxQ;
  assign bus.MOUSE_DY       = dyQ;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm with a 20-cycle power-up wait.
module tb_mouse_master_sm;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   errCnt = 0;
  int   chkCnt = 0;
  int   intCnt = 0;

  mouse_master_sm_if bus();

  mouse_master_sm #(
    .INIT_WAIT_CYCLES (20)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (bus.SEND_INTERRUPT) intCnt++;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns number of cycles until SEND_BYTE is seen (-1 on timeout); also
  // reports whether READ_ENABLE was ever high while waiting.
  task automatic waitSend(output int cyc, output logic reSeen);
    cyc = -1;
    reSeen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      if (bus.SEND_BYTE) begin
        cyc = i;
        break;
      end
      if (bus.READ_ENABLE) reSeen = 1'b1;
    end
  endtask

  task automatic pulseSent();
    bus.BYTE_SENT = 1'b1;
    @(negedge CLK);
    bus.BYTE_SENT = 1'b0;
  endtask

  task automatic feedByte(input logic [7:0] b, input logic [1:0] err);
    bus.BYTE_READ       = b;
    bus.BYTE_ERROR_CODE = err;
    bus.BYTE_READY      = 1'b1;
    @(negedge CLK);
    bus.BYTE_READY      = 1'b0;
    bus.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic checkPowerUp(input string tag);
    int   cyc;
    logic reSeen;
    waitSend(cyc, reSeen);
    checkVal({tag, "_sb_cycle"}, (cyc >= 19 && cyc <= 21), 1);
    checkVal({tag, "_re_before"}, reSeen, 0);
    checkVal({tag, "_byte_ff"}, bus.BYTE_TO_SEND, 8'hFF);
    @(negedge CLK);
    checkVal({tag, "_sb_single"}, bus.SEND_BYTE, 0);
    checkVal({tag, "_byte_held"}, bus.BYTE_TO_SEND, 8'hFF);
  endtask

  task automatic fullInit(input string tag);
    checkPowerUp(tag);
    pulseSent();
    checkVal({tag, "_re_ack"}, bus.READ_ENABLE, 1);
    feedByte(8'hFA, 2'b00);
    feedByte(8'hAA, 2'b00);
    feedByte(8'h00, 2'b00);
    checkVal({tag, "_sb_en"}, bus.SEND_BYTE, 1);
    checkVal({tag, "_byte_f4"}, bus.BYTE_TO_SEND, 8'hF4);
    checkVal({tag, "_re_en_send"}, bus.READ_ENABLE, 0);
    @(negedge CLK);
    checkVal({tag, "_sb_en_single"}, bus.SEND_BYTE, 0);
    // Stray byte while waiting for the transmitter must not disturb anything.
    feedByte(8'h12, 2'b00);
    checkVal({tag, "_f4_held"}, bus.BYTE_TO_SEND, 8'hF4);
    pulseSent();
    feedByte(8'hFA, 2'b00);
    checkVal({tag, "_re_stream"}, bus.READ_ENABLE, 1);
  endtask

  int base;

  initial begin
    bus.BYTE_SENT       = 1'b0;
    bus.BYTE_READ       = 8'h00;
    bus.BYTE_ERROR_CODE = 2'b00;
    bus.BYTE_READY      = 1'b0;

    repeat (3) @(negedge CLK);
    checkVal("rst_sb", bus.SEND_BYTE, 0);
    checkVal("rst_byte", bus.BYTE_TO_SEND, 0);
    checkVal("rst_re", bus.READ_ENABLE, 0);
    checkVal("rst_int", bus.SEND_INTERRUPT, 0);
    checkVal("rst_pkt", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 0);
    RESET = 1'b1;

    fullInit("init1");

    // Packet 1
    #1 base = intCnt;
    feedByte(8'h09, 2'b00);
    feedByte(8'h05, 2'b00);
    feedByte(8'hFB, 2'b00);
    checkVal("pk1_int", bus.SEND_INTERRUPT, 1);
    checkVal("pk1_status", bus.MOUSE_STATUS, 8'h09);
    checkVal("pk1_dx", bus.MOUSE_DX, 8'h05);
    checkVal("pk1_dy", bus.MOUSE_DY, 8'hFB);
    @(negedge CLK);
    checkVal("pk1_int_off", bus.SEND_INTERRUPT, 0);
    checkVal("pk1_held", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h0905FB);
    #1 checkVal("pk1_int_cnt", intCnt - base, 1);

    // Resync: 0x01 lacks bit 3 and is dropped
    base = intCnt;
    feedByte(8'h01, 2'b00);
    checkVal("rs_no_int", bus.SEND_INTERRUPT, 0);
    feedByte(8'h08, 2'b00);
    feedByte(8'h00, 2'b00);
    checkVal("rs_no_int2", bus.SEND_INTERRUPT, 0);
    feedByte(8'h00, 2'b00);
    checkVal("rs_int", bus.SEND_INTERRUPT, 1);
    checkVal("rs_pkt", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h080000);
    @(negedge CLK);
    #1 checkVal("rs_int_cnt", intCnt - base, 1);

    // Receive error while streaming forces re-init; packet must survive
    feedByte(8'h08, 2'b01);
    checkVal("err_re", bus.READ_ENABLE, 0);
    checkVal("err_pkt_held", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h080000);
    checkPowerUp("reinit");

    // Bad self-test response restarts power-up
    pulseSent();
    feedByte(8'hFA, 2'b00);
    feedByte(8'hFC, 2'b00);
    checkVal("bad_st_re", bus.READ_ENABLE, 0);
    checkPowerUp("bad_st");
    checkVal("bad_st_pkt_held", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 24'h080000);

    // Finish init, then reset in the middle of a packet
    pulseSent();
    feedByte(8'hFA, 2'b00);
    feedByte(8'hAA, 2'b00);
    feedByte(8'h00, 2'b00);
    @(negedge CLK);
    pulseSent();
    feedByte(8'hFA, 2'b00);
    checkVal("init2_re", bus.READ_ENABLE, 1);
    #1 base = intCnt;
    feedByte(8'h09, 2'b00);
    feedByte(8'h05, 2'b00);
    #2 RESET = 1'b0;
    #1;
    checkVal("mid_rst_pkt", {bus.MOUSE_STATUS, bus.MOUSE_DX, bus.MOUSE_DY}, 0);
    checkVal("mid_rst_sb", bus.SEND_BYTE, 0);
    checkVal("mid_rst_byte", bus.BYTE_TO_SEND, 0);
    checkVal("mid_rst_re", bus.READ_ENABLE, 0);
    checkVal("mid_rst_int", bus.SEND_INTERRUPT, 0);
    @(negedge CLK);
    feedByte(8'hFB, 2'b00);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1 checkVal("mid_rst_int_cnt", intCnt - base, 0);
    checkPowerUp("restart");

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mouse_master_sm.md
MOUSE_MASTER_SM -- requirements
Module: mouse_master_sm

Interface
REQ-001 SHALL have parameter INIT_WAIT_CYCLES, default 1_000_000, giving the power-up wait in CLK cycles (10 ms at 100 MHz).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: CLK input 1 system clock, rising edge; RESET input 1 asynchronous reset, asserted at 0.
REQ-003 SHALL have port SEND_BYTE, output, 1 bit: one-cycle request to the transmitter.
REQ-004 SHALL have port BYTE_TO_SEND, output, 8 bits: command byte for the transmitter.
REQ-005 SHALL have port BYTE_SENT, input, 1 bit: transmitter finished the byte (pulse).
REQ-006 SHALL have port READ_ENABLE, output, 1 bit: enables the receiver.
REQ-007 SHALL have port BYTE_READ, input, 8 bits: byte received from the mouse.
REQ-008 SHALL have port BYTE_ERROR_CODE, input, 2 bits: 00 means OK; nonzero means parity or framing error.
REQ-009 SHALL have port BYTE_READY, input, 1 bit: one-cycle pulse when BYTE_READ is valid.
REQ-010 SHALL have ports MOUSE_STATUS, MOUSE_DX and MOUSE_DY, outputs, 8 bits each: last complete packet bytes 1, 2 and 3.
REQ-011 SHALL have port SEND_INTERRUPT, output, 1 bit: one-cycle pulse when a new packet is valid.

Function
REQ-012 SHALL implement these states: INIT_WAIT, SEND_RESET, WAIT_RESET_SENT, WAIT_ACK, WAIT_SELFTEST, WAIT_ID, SEND_ENABLE, WAIT_ENABLE_SENT, WAIT_ENABLE_ACK, READ_STATUS, READ_DX, READ_DY, INTERRUPT.
REQ-013 INIT_WAIT SHALL count CLK cycles and move to SEND_RESET once the count reaches INIT_WAIT_CYCLES-1.
REQ-014 SEND_RESET SHALL, for exactly one cycle, assert SEND_BYTE with BYTE_TO_SEND=0xFF, then go to WAIT_RESET_SENT.
REQ-015 WAIT_RESET_SENT SHALL go to WAIT_ACK when BYTE_SENT=1.
REQ-016 BYTE_TO_SEND SHALL be registered and held stable from the send state until BYTE_SENT.
REQ-017 In WAIT_ACK, WAIT_SELFTEST and WAIT_ID, each BYTE_READY pulse SHALL be checked against 0xFA, 0xAA and 0x00 respectively, with error code 00.
  - Match: advance to the next state.
  - Anything else: return to INIT_WAIT with the counter cleared.
REQ-018 SEND_ENABLE SHALL send 0xF4 using the same one-cycle rule as SEND_RESET, then go to WAIT_ENABLE_SENT.
REQ-019 WAIT_ENABLE_SENT SHALL go to WAIT_ENABLE_ACK on BYTE_SENT; WAIT_ENABLE_ACK SHALL require 0xFA with error 00, else return to INIT_WAIT.
REQ-020 READ_ENABLE SHALL be 1 in every WAIT_ACK/SELFTEST/ID/ENABLE_ACK and READ_* state, and 0 otherwise.
REQ-021 READ_STATUS SHALL handle each byte as follows:
  - Bit3=1 and error 00: latch into an internal shadow register and go to READ_DX.
  - Bit3=0: discard and stay (resync).
  - Nonzero error: go to INIT_WAIT.
REQ-022 READ_DX and READ_DY SHALL latch the byte into shadow registers when error is 00, else go to INIT_WAIT; READ_DY then goes to INTERRUPT.
REQ-023 On entry to INTERRUPT, MOUSE_STATUS, MOUSE_DX and MOUSE_DY SHALL update together from the shadow registers, and SEND_INTERRUPT SHALL be 1 for exactly that one cycle.
REQ-024 During the SEND_INTERRUPT cycle the three outputs SHALL already hold the new packet, so a consumer can sample them in the same cycle.
REQ-025 INTERRUPT SHALL go to READ_STATUS on the next cycle.
REQ-026 BYTE_READY in a state that does not read SHALL be ignored.
REQ-027 BYTE_SENT outside WAIT_*_SENT SHALL be ignored.
REQ-028 BYTE_READY and BYTE_SENT arriving in the same cycle SHALL be handled by the current state only.
REQ-029 The packet outputs SHALL hold their values between interrupts and through any re-initialisation.

Reset
REQ-030 When RESET=0, the block SHALL asynchronously enter INIT_WAIT with the counter cleared.
REQ-031 When RESET=0, every output SHALL go to 0: SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS/DX/DY and SEND_INTERRUPT.
REQ-032 When RESET=0, the shadow registers SHALL also clear to 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer; after release the block SHALL restart the full power-up sequence.

Structure
REQ-034 The shared package mouse_pkg SHALL hold:
  - the state enumeration;
  - the command and response constants CMD_RESET=0xFF, CMD_ENABLE=0xF4, RSP_ACK=0xFA, RSP_SELFTEST=0xAA, RSP_ID=0x00;
  - ERR_NONE=2'b00.
REQ-035 The power-up counter SHALL be one sub-module, mouse_startup_timer (clear/enable in, done out); all other logic stays flat.

Verification
REQ-036 Bench SHALL use INIT_WAIT_CYCLES=20 and cover these scenarios:
  - Power-up, then release reset: SEND_BYTE pulses once with 0xFF at cycle 20 (±1); READ_ENABLE=0 before it.
  - BYTE_SENT, then feed FA, AA, 00: a single SEND_BYTE with 0xF4; after BYTE_SENT and FA, READ_ENABLE=1.
  - Stream 0x09, 0x05, 0xFB: a single SEND_INTERRUPT with STATUS=0x09, DX=0x05, DY=0xFB in the same cycle.
  - During init, feed 0xFC instead of 0xAA: return to INIT_WAIT and resend 0xFF after 20 cycles.
  - While streaming, feed 0x01 (bit3=0) then 0x08, 0x00, 0x00: first byte ignored; interrupt with STATUS=0x08.
  - Assert RESET=0 mid-packet: outputs become 0 immediately, with no SEND_INTERRUPT.
